// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider: WIDTH cycles of shift/subtract, one sign-fix cycle, one done cycle.
// Optional DIV_ZERO_FAST_EN: zero divisors finish in one cycle and raise div_zero.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             Sign,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] prem_q, prem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;

  logic [WIDTH-1:0] abs1, abs2;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] trial;
  logic             fits;

  assign abs1 = (Sign & in1[WIDTH-1]) ? -in1 : in1;
  assign abs2 = (Sign & in2[WIDTH-1]) ? -in2 : in2;

  // dvd_q holds the unconsumed dividend bits at the top and collects quotient bits at the bottom
  assign shifted = {prem_q, dvd_q[WIDTH-1]};
  assign fits    = (shifted >= {1'b0, dvs_q});
  assign trial   = shifted[WIDTH-1:0] - dvs_q;

`ifdef DIV_ZERO_FAST_EN
  logic dz_q, dz_d;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    prem_d    = prem_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
`ifdef DIV_ZERO_FAST_EN
    dz_d      = dz_q;
`endif
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          state_d = IDLE;
          if (start) begin
            state_d   = RUN;
            cnt_d     = '0;
            prem_d    = '0;
            dvd_d     = abs1;
            dvs_d     = abs2;
            neg_quo_d = Sign & (in1[WIDTH-1] ^ in2[WIDTH-1]);
            neg_rem_d = Sign & in1[WIDTH-1];
`ifdef DIV_ZERO_FAST_EN
            if (in2 == '0) begin
              state_d = DONE;
              quo_d   = '1;
              rem_d   = in1;
              dz_d    = 1'b1;
            end
`endif
          end
        end
        RUN: begin
          if (fits) begin
            prem_d = trial;
            dvd_d  = {dvd_q[WIDTH-2:0], 1'b1};
          end else begin
            prem_d = shifted[WIDTH-1:0];
            dvd_d  = {dvd_q[WIDTH-2:0], 1'b0};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d = FIX;
          end
        end
        FIX: begin
          quo_d   = neg_quo_q ? -dvd_q : dvd_q;
          rem_d   = neg_rem_q ? -prem_q : prem_q;
`ifdef DIV_ZERO_FAST_EN
          dz_d    = 1'b0;
`endif
          state_d = DONE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      prem_q    <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      quo_q     <= '0;
      rem_q     <= '0;
`ifdef DIV_ZERO_FAST_EN
      dz_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      prem_q    <= prem_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
`ifdef DIV_ZERO_FAST_EN
      dz_q      <= dz_d;
`endif
    end
  end

  assign busy      = (state_q == RUN) || (state_q == FIX);
  assign done      = (state_q == DONE);
  assign quotient  = quo_q;
  assign remainder = rem_q;
`ifdef DIV_ZERO_FAST_EN
  assign div_zero  = dz_q;
`else
  assign div_zero  = 1'b0;
`endif

endmodule
